// File: rtl/word_to_row_packer.sv
// Packs the 32-bit host word stream into complete image rows for cnn_layer.
// One row fills while the previous row is presented, so filling and draining overlap.
module word_to_row_packer #(
    parameter int unsigned VALUE_BITS      = 8,
    parameter int unsigned VALUES_PER_WORD = 1,
    parameter int unsigned WIDTH           = 28,
    parameter int unsigned HEIGHT          = 28,
    parameter int unsigned IN_CHANNELS     = 1
) (
    input  logic                                                 clock_i,
    input  logic                                                 reset_n_i,
    input  logic [31:0]                                          in_data_i,
    input  logic                                                 in_valid_i,
    output logic                                                 in_stall_o,
    output logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0]    out_row_o,
    output logic                                                 out_row_valid_o,
    input  logic                                                 out_row_accept_i,
    output logic                                                 out_row_last_o
);

    localparam int unsigned ROW_VALUES    = WIDTH * IN_CHANNELS;
    localparam int unsigned WORDS_PER_ROW = ROW_VALUES / VALUES_PER_WORD;
    localparam int unsigned WORD_IDX_W    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int unsigned ROW_IDX_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned PIX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CH_W          = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;

    typedef logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row_t;

    row_t                  fill_q,      fill_d;
    row_t                  out_row_q,   out_row_d;
    logic [WORD_IDX_W-1:0] word_idx_q,  word_idx_d;
    logic [ROW_IDX_W-1:0]  row_idx_q,   row_idx_d;
    logic                  fill_full_q, fill_full_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;

    logic                  word_accept_c;
    logic                  row_done_c;
    logic                  slot_free_c;
    logic                  row_is_last_c;
    logic [ROW_IDX_W-1:0]  row_idx_next_c;

    // Upper word bits beyond the packed lanes are don't-care.
    logic unused_in_bits;
    assign unused_in_bits = ^in_data_i;

    assign in_stall_o      = fill_full_q;
    assign out_row_o       = out_row_q;
    assign out_row_valid_o = out_valid_q;
    assign out_row_last_o  = out_last_q;

    always_comb begin
        fill_d      = fill_q;
        out_row_d   = out_row_q;
        word_idx_d  = word_idx_q;
        row_idx_d   = row_idx_q;
        fill_full_d = fill_full_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        word_accept_c  = in_valid_i && !fill_full_q;
        row_done_c     = word_accept_c && (word_idx_q == WORD_IDX_W'(WORDS_PER_ROW - 1));
        slot_free_c    = !out_valid_q || out_row_accept_i;
        row_is_last_c  = (row_idx_q == ROW_IDX_W'(HEIGHT - 1));
        row_idx_next_c = row_is_last_c ? '0 : row_idx_q + ROW_IDX_W'(1);

        // Scatter the word's lanes into the fill row at the current word slot.
        if (word_accept_c) begin
            for (int unsigned w = 0; w < WORDS_PER_ROW; w++) begin
                if (word_idx_q == WORD_IDX_W'(w)) begin
                    for (int unsigned j = 0; j < VALUES_PER_WORD; j++) begin
                        fill_d[PIX_W'((w * VALUES_PER_WORD + j) / IN_CHANNELS)]
                              [CH_W'((w * VALUES_PER_WORD + j) % IN_CHANNELS)]
                            = in_data_i[5'(VALUE_BITS * j) +: VALUE_BITS];
                    end
                end
            end
            word_idx_d = row_done_c ? '0 : word_idx_q + WORD_IDX_W'(1);
        end

        // Completed rows bypass the fill buffer when the output slot frees this cycle.
        if (row_done_c && slot_free_c) begin
            out_row_d   = fill_d;
            out_valid_d = 1'b1;
            out_last_d  = row_is_last_c;
            row_idx_d   = row_idx_next_c;
        end else if (row_done_c) begin
            fill_full_d = 1'b1;
        end else if (out_valid_q && out_row_accept_i) begin
            if (fill_full_q) begin
                out_row_d   = fill_q;
                out_valid_d = 1'b1;
                out_last_d  = row_is_last_c;
                row_idx_d   = row_idx_next_c;
                fill_full_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            fill_q      <= '0;
            out_row_q   <= '0;
            word_idx_q  <= '0;
            row_idx_q   <= '0;
            fill_full_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            out_row_q   <= out_row_d;
            word_idx_q  <= word_idx_d;
            row_idx_q   <= row_idx_d;
            fill_full_q <= fill_full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_word_to_row_packer.sv
// Scoreboard bench for word_to_row_packer: expected rows are queued as their last
// word is accepted and compared when the DUT hands a row downstream.
module tb_word_to_row_packer;

    localparam int unsigned VB = 8;
    localparam int unsigned W  = 28;
    localparam int unsigned H  = 28;
    localparam int unsigned IC = 1;

    typedef logic [W-1:0][IC-1:0][VB-1:0] row_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        accept;
    logic        stall;
    row_t        row;
    logic        valid;
    logic        last;

    logic [31:0] in_data4;
    logic        in_valid4;
    logic        accept4;
    logic        stall4;
    row_t        row4;
    logic        valid4;
    logic        last4;

    always #5 clk = ~clk;

    word_to_row_packer #(
        .VALUE_BITS(VB), .VALUES_PER_WORD(1), .WIDTH(W), .HEIGHT(H), .IN_CHANNELS(IC)
    ) dut (
        .clock_i(clk), .reset_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_stall_o(stall), .out_row_o(row), .out_row_valid_o(valid),
        .out_row_accept_i(accept), .out_row_last_o(last)
    );

    word_to_row_packer #(
        .VALUE_BITS(VB), .VALUES_PER_WORD(4), .WIDTH(W), .HEIGHT(H), .IN_CHANNELS(IC)
    ) dut4 (
        .clock_i(clk), .reset_n_i(rst_n), .in_data_i(in_data4), .in_valid_i(in_valid4),
        .in_stall_o(stall4), .out_row_o(row4), .out_row_valid_o(valid4),
        .out_row_accept_i(accept4), .out_row_last_o(last4)
    );

    row_t exp_rows[$];
    logic exp_last[$];
    row_t cur_row;
    int   word_cnt;
    int   rows_sent;
    int   n_tests;
    int   n_fail;
    int   last_seen;
    bit   stall_seen;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic row_t mk_row(input int base);
        row_t r;
        r = '0;
        for (int k = 0; k < W; k++) r[5'(k)][0] = 8'(base + k);
        return r;
    endfunction

    // Drive one word until accepted; queue the expected row when it completes.
    task automatic send_word(input logic [7:0] v);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        in_data  = {24'h0, v};
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = !stall;
            @(posedge clk);
            #1;
            tries++;
            if (!acc && tries > 50) begin
                check("accept_timeout", 256'(0), 256'(1));
                break;
            end
        end
        in_valid = 1'b0;
        if (acc) begin
            cur_row[5'(word_cnt)][0] = v;
            word_cnt++;
            if (word_cnt == W) begin
                exp_rows.push_back(cur_row);
                exp_last.push_back((rows_sent % H) == (H - 1));
                rows_sent++;
                word_cnt = 0;
            end
        end
    endtask

    // Compare each row as it is handed downstream (transfer happens at the next rising edge).
    row_t mon_row;
    logic mon_last;
    always @(negedge clk) begin
        if (rst_n && valid && accept) begin
            if (exp_rows.size() == 0) begin
                check("unexpected_row", 256'(1), 256'(0));
            end else begin
                mon_row  = exp_rows.pop_front();
                mon_last = exp_last.pop_front();
                check("row_data", 256'(row), 256'(mon_row));
                check("row_last", 256'(last), 256'(mon_last));
            end
            if (last) last_seen++;
        end
        if (stall) stall_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; word_cnt = 0; rows_sent = 0; last_seen = 0;
        stall_seen = 1'b0; cur_row = '0;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; accept = 1'b0;
        in_data4 = '0; in_valid4 = 1'b0; accept4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 256'(valid), 256'(0));
        check("rst_stall", 256'(stall), 256'(0));
        check("rst_last",  256'(last),  256'(0));
        check("rst_row",   256'(row),   256'(0));
        check("rst_valid4", 256'(valid4), 256'(0));
        rst_n = 1'b1;

        // Four lanes per word: row completes on the seventh word.
        for (int i = 0; i < 7; i++) begin
            in_data4  = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
            in_valid4 = 1'b1;
            @(posedge clk);
            #1;
            if (i == 5) check("vpw4_early", 256'(valid4), 256'(0));
        end
        in_valid4 = 1'b0;
        check("vpw4_valid", 256'(valid4), 256'(1));
        check("vpw4_row",   256'(row4),   256'(mk_row(0)));
        check("vpw4_last",  256'(last4),  256'(0));
        @(posedge clk);
        #1;
        check("vpw4_drain", 256'(valid4), 256'(0));

        // Single row with accept held high.
        accept = 1'b1;
        stall_seen = 1'b0;
        for (int k = 0; k < W; k++) begin
            send_word(8'(k));
            if (k == W - 2) check("t1_not_early", 256'(valid), 256'(0));
        end
        check("t1_valid_latency", 256'(valid), 256'(1));
        check("t1_last", 256'(last), 256'(0));
        @(posedge clk);
        #1;
        check("t1_valid_pulse", 256'(valid), 256'(0));
        check("t1_no_stall", 256'(stall_seen), 256'(0));

        // Backpressure: A presented, B held, C blocked.
        accept = 1'b0;
        for (int k = 0; k < W; k++) send_word(8'(k));
        for (int k = 0; k < W; k++) send_word(8'(100 + k));
        check("bp_stall", 256'(stall), 256'(1));
        check("bp_valid", 256'(valid), 256'(1));
        check("bp_row_a", 256'(row), 256'(mk_row(0)));
        in_data  = 32'd200;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_c_blocked", 256'(stall), 256'(1));
        end
        in_valid = 1'b0;
        check("bp_row_a_stable", 256'(row), 256'(mk_row(0)));
        accept = 1'b1;
        @(posedge clk);
        #1;
        accept = 1'b0;
        check("bp_b_valid", 256'(valid), 256'(1));
        check("bp_b_row",   256'(row),   256'(mk_row(100)));
        check("bp_unstall", 256'(stall), 256'(0));

        // Accept of B coincides with the last word of C.
        stall_seen = 1'b0;
        for (int k = 0; k < W - 1; k++) send_word(8'(50 + k));
        accept = 1'b1;
        send_word(8'(50 + W - 1));
        accept = 1'b0;
        check("sim_valid", 256'(valid), 256'(1));
        check("sim_row",   256'(row),   256'(mk_row(50)));
        check("sim_stall", 256'(stall), 256'(0));
        @(posedge clk);
        #1;
        check("sim_no_stall_pulse", 256'(stall_seen), 256'(0));
        check("sim_row_hold", 256'(row), 256'(mk_row(50)));
        accept = 1'b1;
        @(posedge clk);
        #1;
        check("sim_drain", 256'(valid), 256'(0));

        // Frame boundary: rows 4..29, last only on row index 27.
        last_seen = 0;
        for (int r = 4; r < 30; r++)
            for (int k = 0; k < W; k++) send_word(8'(r * 3 + k));
        @(posedge clk);
        #1;
        check("frame_last_count", 256'(last_seen), 256'(1));
        check("frame_sb_empty", 256'(exp_rows.size()), 256'(0));

        // Reset mid-row discards the partial row.
        for (int k = 0; k < 10; k++) send_word(8'(240 + k));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_rows.delete();
        exp_last.delete();
        word_cnt = 0;
        rows_sent = 0;
        check("mid_rst_valid", 256'(valid), 256'(0));
        check("mid_rst_stall", 256'(stall), 256'(0));
        for (int k = 0; k < W; k++) send_word(8'(200 + k));
        check("mid_rst_row",  256'(row),   256'(mk_row(200)));
        check("mid_rst_last", 256'(last),  256'(0));
        check("mid_rst_valid_out", 256'(valid), 256'(1));
        @(posedge clk);
        #1;
        check("final_sb_empty", 256'(exp_rows.size()), 256'(0));
        check("final_idle", 256'(valid), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
